// File: rtl/idct4_row.sv
// idct4_row: serial 4-point integer inverse transform for the JPEG decode path.
// Collects one row of four signed coefficients, recombines them through an
// even/odd butterfly in a single CALC cycle, then streams four samples out.
// Optional build macro IDCT4_PIXEL_CLAMP_EN: level-shift each sample by +128
// and clamp to an unsigned 8-bit pixel before it is registered.
module idct4_row #(
    parameter int IN_W  = 12,
    parameter int OUT_W = IN_W + 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_last,
    output logic                    busy
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_nxt;
    logic [1:0] r_ocnt;
    logic [1:0] w_ocnt_nxt;

    logic w_vld_p0;
    logic w_vld_p1;

    logic signed [IN_W-1:0]  r_c_p0 [4];
    logic signed [OUT_W-1:0] r_x_p1 [4];

    logic signed [OUT_W-1:0] w_c  [4];
    logic signed [OUT_W-1:0] w_e  [4];
    logic signed [OUT_W-1:0] w_x  [4];
    logic signed [OUT_W-1:0] w_y  [4];

    // Widen a coefficient to the output width, preserving its sign.
    function automatic logic signed [OUT_W-1:0] sext(input logic signed [IN_W-1:0] v);
        return OUT_W'(v);
    endfunction

`ifdef IDCT4_PIXEL_CLAMP_EN
    localparam logic signed [OUT_W-1:0] PIX_OFS = OUT_W'(128);
    localparam logic signed [OUT_W-1:0] PIX_MAX = OUT_W'(255);

    // Level shift into the pixel domain and saturate to [0,255].
    function automatic logic signed [OUT_W-1:0] pix_clamp(input logic signed [OUT_W-1:0] x);
        logic signed [OUT_W-1:0] y;
        y = x + PIX_OFS;
        if (y < 0)
            return '0;
        else if (y > PIX_MAX)
            return PIX_MAX;
        else
            return y;
    endfunction
`endif

    assign w_vld_p0  = in_valid && in_ready;
    assign w_vld_p1  = out_valid && out_ready;

    assign in_ready  = (r_state == LOAD);
    assign out_valid = (r_state == SEND);
    assign out_data  = out_valid ? r_x_p1[r_ocnt] : '0;
    assign out_last  = out_valid && (r_ocnt == 2'd3);
    assign busy      = (r_state != LOAD) || (r_cnt != 2'd0);

    // Butterfly recombination of the buffered row; >>> floors toward -inf.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_c[i] = sext(r_c_p0[i]);
        end
        w_e[0] = w_c[0] + w_c[2];
        w_e[1] = w_c[0] - w_c[2];
        w_e[2] = (w_c[1] >>> 1) - w_c[3];
        w_e[3] = w_c[1] + (w_c[3] >>> 1);
        w_x[0] = w_e[0] + w_e[3];
        w_x[1] = w_e[1] + w_e[2];
        w_x[2] = w_e[1] - w_e[2];
        w_x[3] = w_e[0] - w_e[3];
        for (int i = 0; i < 4; i++) begin
`ifdef IDCT4_PIXEL_CLAMP_EN
            w_y[i] = pix_clamp(w_x[i]);
`else
            w_y[i] = w_x[i];
`endif
        end
    end

    // Next-state and counter logic for the LOAD -> CALC -> SEND cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ocnt_nxt  = r_ocnt;
        case (r_state)
            LOAD: begin
                if (w_vld_p0) begin
                    w_cnt_nxt = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_cnt_nxt   = 2'd0;
                        w_state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                w_state_nxt = SEND;
            end
            SEND: begin
                if (w_vld_p1) begin
                    w_ocnt_nxt = r_ocnt + 2'd1;
                    if (r_ocnt == 2'd3) begin
                        w_ocnt_nxt  = 2'd0;
                        w_state_nxt = LOAD;
                    end
                end
            end
            default: begin
                w_state_nxt = LOAD;
                w_cnt_nxt   = 2'd0;
                w_ocnt_nxt  = 2'd0;
            end
        endcase
    end

    // Control registers; reset drops any partial row or pending output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOAD;
            r_cnt   <= 2'd0;
            r_ocnt  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ocnt  <= w_ocnt_nxt;
        end
    end

    // Stage p0: coefficient capture into the row buffer.
    always_ff @(posedge clk) begin
        if (w_vld_p0) begin
            r_c_p0[r_cnt] <= in_data;
        end
    end

    // Stage p1: transform results, registered during the CALC cycle.
    always_ff @(posedge clk) begin
        if (r_state == CALC) begin
            for (int i = 0; i < 4; i++) begin
                r_x_p1[i] <= w_y[i];
            end
        end
    end

endmodule

// File: tb/tb_idct4_row.sv
// Testbench for idct4_row: directed rows from the test plan plus random rows
// checked against a plain-arithmetic reference of the inverse transform.
module tb_idct4_row;

    localparam int IN_W  = 12;
    localparam int OUT_W = IN_W + 3;

    logic                    clk;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_last;
    logic                    busy;

    int n_assert = 0;
    int n_fail   = 0;

    int cv[4];
    int gv[4];
    int ev[4];

    idct4_row #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int fl2(input int v);
        return (v >= 0) ? v / 2 : -((-v + 1) / 2);
    endfunction

    // Reference: x = inverse butterfly of c, optionally mapped to a pixel.
    task automatic ref_row();
        int e0, e1, e2, e3;
        int x[4];
        e0 = cv[0] + cv[2];
        e1 = cv[0] - cv[2];
        e2 = fl2(cv[1]) - cv[3];
        e3 = cv[1] + fl2(cv[3]);
        x[0] = e0 + e3;
        x[1] = e1 + e2;
        x[2] = e1 - e2;
        x[3] = e0 - e3;
        for (int i = 0; i < 4; i++) begin
`ifdef IDCT4_PIXEL_CLAMP_EN
            ev[i] = (x[i] + 128 < 0) ? 0 : ((x[i] + 128 > 255) ? 255 : x[i] + 128);
`else
            ev[i] = x[i];
`endif
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data",  int'($signed(out_data)), 0);
        chk("rst_out_last",  int'(out_last), 0);
        chk("rst_busy",      int'(busy), 0);
        chk("rst_in_ready",  int'(in_ready), 1);
    endtask

    task automatic feed_row();
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gv[i]; g++) begin
                in_valid = 1'b0;
                in_data  = IN_W'($urandom);
                tick();
                chk("gap_in_ready", int'(in_ready), 1);
                chk("gap_busy", int'(busy), (i > 0) ? 1 : 0);
            end
            in_valid = 1'b1;
            in_data  = IN_W'(cv[i]);
            chk("load_in_ready", int'(in_ready), 1);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic run_row(input logic [15:0] pat);
        int idx;
        int cyc;
        logic rdy;
        feed_row();
        chk("calc_in_ready",  int'(in_ready), 0);
        chk("calc_out_valid", int'(out_valid), 0);
        chk("calc_busy",      int'(busy), 1);
        tick();
        idx = 0;
        cyc = 0;
        while (idx < 4 && cyc < 64) begin
            chk("send_out_valid", int'(out_valid), 1);
            chk("send_out_data",  int'($signed(out_data)), ev[idx]);
            chk("send_out_last",  int'(out_last), (idx == 3) ? 1 : 0);
            chk("send_in_ready",  int'(in_ready), 0);
            rdy       = (cyc < 16) ? pat[cyc] : 1'b1;
            out_ready = rdy;
            in_valid  = 1'b1;
            in_data   = IN_W'($urandom);
            tick();
            if (rdy) idx++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("xfer_count",     idx, 4);
        chk("post_in_ready",  int'(in_ready), 1);
        chk("post_out_valid", int'(out_valid), 0);
        chk("post_busy",      int'(busy), 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        do_reset();

        gv = '{0, 0, 0, 0};
        cv = '{64, 0, 0, 0};
`ifdef IDCT4_PIXEL_CLAMP_EN
        ev = '{192, 192, 192, 192};
`else
        ev = '{64, 64, 64, 64};
`endif
        run_row(16'hFFFF);

        cv = '{0, 8, 0, 0};
`ifdef IDCT4_PIXEL_CLAMP_EN
        ev = '{136, 132, 124, 120};
`else
        ev = '{8, 4, -4, -8};
`endif
        run_row(16'hFFFF);

        cv = '{10, 0, 4, 2};
`ifdef IDCT4_PIXEL_CLAMP_EN
        ev = '{143, 132, 136, 141};
`else
        ev = '{15, 4, 8, 13};
`endif
        run_row(16'hFFFF);

        cv = '{0, -3, 0, 0};
`ifdef IDCT4_PIXEL_CLAMP_EN
        ev = '{125, 126, 130, 131};
`else
        ev = '{-3, -2, 2, 3};
`endif
        run_row(16'hFFFF);

        // Backpressure 1,0,0,1,0,1,1 on out_ready.
        cv = '{0, 8, 0, 0};
        ref_row();
        run_row(16'hFFE9);

        // Gapped input: c0@0, c1@3, c2@4, c3@9.
        gv = '{0, 2, 0, 4};
        cv = '{10, 0, 4, 2};
        ref_row();
        run_row(16'hFFFF);
        gv = '{0, 0, 0, 0};

        // Reset after two coefficients, then a clean row.
        in_valid = 1'b1;
        in_data  = IN_W'(500);
        tick();
        in_data  = IN_W'(-700);
        tick();
        in_valid = 1'b0;
        chk("partial_busy", int'(busy), 1);
        do_reset();
        cv = '{10, 0, 4, 2};
        ref_row();
        run_row(16'hFFFF);

        // Reset during SEND.
        cv = '{64, 0, 0, 0};
        feed_row();
        tick();
        chk("presend_out_valid", int'(out_valid), 1);
        out_ready = 1'b0;
        do_reset();

`ifdef IDCT4_PIXEL_CLAMP_EN
        cv = '{200, 0, 0, 0};
        ev = '{255, 255, 255, 255};
        run_row(16'hFFFF);
        cv = '{-200, 0, 0, 0};
        ev = '{0, 0, 0, 0};
        run_row(16'hFFFF);
`endif

        // Random rows, random gaps and random backpressure.
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 4; i++) begin
                cv[i] = int'($urandom_range(0, 4095)) - 2048;
                gv[i] = int'($urandom_range(0, 2));
            end
            ref_row();
            run_row(16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
